// File: rtl/nlu_pkg.sv
// Shared types and constants for the nonlinear-unit issue stage.
package nlu_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic        modenl;
        logic        modeAES;
    } nlu_req_t;

    localparam logic NLU_CFG_MASK_LO = 1'b0;
    localparam logic NLU_CFG_MASK_HI = 1'b1;

    localparam logic NLU_MODE_ANF = 1'b0;
    localparam logic NLU_MODE_AES = 1'b1;
    localparam logic NLU_AES_ENC  = 1'b0;
    localparam logic NLU_AES_DEC  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } nlu_commit_state_t;

endpackage

// File: rtl/nlu_issue_fifo.sv
// Synchronous FIFO of nlu_req_t with registered storage; head is read directly from storage.
module nlu_issue_fifo
    import nlu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  nlu_req_t      din,
    input  logic          pop,
    output nlu_req_t      dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    nlu_req_t        mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign count  = count_r;
    assign dout   = mem_r[rd_ptr_r];
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/nlu_issue_stage.sv
// Issue stage for the nonlinear unit: request FIFO plus shadow/committed ANF mask.
// Optional performance counters are enabled by defining NLU_ISSUE_PERF_EN.
module nlu_issue_stage
    import nlu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] MASK_RST = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic        cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic        cfg_busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic        in_modenl,
    input  logic        in_modeAES,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [63:0] out_m,
    output logic        out_modenl,
    output logic        out_modeAES
`ifdef NLU_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_issued,
    output logic [31:0] perf_stall
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    nlu_req_t          din_s;
    nlu_req_t          head_s;
    logic              full_s;
    logic              empty_s;
    logic [CW-1:0]     count_s;
    logic [CW-1:0]     count_nxt_s;
    logic              push_s;
    logic              pop_s;
    logic              hi_wr_s;
    logic              commit_s;
    logic              in_ready_r;
    logic [63:0]       shadow_r;
    logic [63:0]       shadow_nxt_s;
    logic [63:0]       mask_r;
    nlu_commit_state_t state_r;
    nlu_commit_state_t state_nxt_s;

    assign din_s   = '{a: in_a, modenl: in_modenl, modeAES: in_modeAES};
    assign push_s  = in_valid && in_ready_r && !full_s;
    assign pop_s   = out_valid && out_ready;
    assign hi_wr_s = cfg_we && (cfg_addr == NLU_CFG_MASK_HI);

    nlu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (din_s),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    assign out_valid   = !empty_s;
    assign out_a       = head_s.a;
    assign out_modenl  = head_s.modenl;
    assign out_modeAES = head_s.modeAES;
    assign out_m       = mask_r;
    assign cfg_busy    = (state_r == ST_PEND);
    assign in_ready    = in_ready_r;

    // Occupancy after this edge, used to register in_ready one cycle ahead.
    always_comb begin
        count_nxt_s = count_s;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_s + CW'(1);
            2'b01:   count_nxt_s = count_s - CW'(1);
            default: count_nxt_s = count_s;
        endcase
    end

    // Shadow value including any config write landing this cycle.
    always_comb begin
        shadow_nxt_s = shadow_r;
        if (cfg_we && (cfg_addr == NLU_CFG_MASK_LO)) begin
            shadow_nxt_s[31:0] = cfg_wdata;
        end else if (hi_wr_s) begin
            shadow_nxt_s[63:32] = cfg_wdata;
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Commit FSM: a mask only moves to out_m once no accepted entry can still observe the old one.
    always_comb begin
        state_nxt_s = state_r;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (hi_wr_s && empty_s && !push_s) begin
                    commit_s = 1'b1;
                end else if (hi_wr_s) begin
                    state_nxt_s = ST_PEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (empty_s && !push_s) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PEND;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Mask registers, commit state and the registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            shadow_r   <= 64'h0;
            mask_r     <= MASK_RST;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shadow_r   <= shadow_nxt_s;
            mask_r     <= commit_s ? shadow_nxt_s : mask_r;
            in_ready_r <= (count_nxt_s != CW'(DEPTH)) && (state_nxt_s != ST_PEND);
        end
    end

`ifdef NLU_ISSUE_PERF_EN
    logic [31:0] perf_issued_r;
    logic [31:0] perf_stall_r;

    // Free-running, wrapping event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued_r <= 32'd0;
            perf_stall_r  <= 32'd0;
        end else begin
            perf_issued_r <= perf_issued_r + {31'd0, pop_s};
            perf_stall_r  <= perf_stall_r + {31'd0, (in_valid && !in_ready_r)};
        end
    end

    assign perf_issued = perf_issued_r;
    assign perf_stall  = perf_stall_r;
`endif

endmodule

// File: tb/tb_nlu_issue_stage.sv
// Self-checking bench for nlu_issue_stage against a queue-based behavioural model.
module tb_nlu_issue_stage;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] MASK_RST = 64'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we, cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_busy;
    logic        in_valid, in_ready;
    logic [31:0] in_a;
    logic        in_modenl, in_modeAES;
    logic        out_valid, out_ready;
    logic [31:0] out_a;
    logic [63:0] out_m;
    logic        out_modenl, out_modeAES;
`ifdef NLU_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    always #5 clk = ~clk;

    nlu_issue_stage #(.DEPTH(DEPTH), .MASK_RST(MASK_RST)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_busy(cfg_busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_modenl(in_modenl), .in_modeAES(in_modeAES),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_m(out_m),
        .out_modenl(out_modenl), .out_modeAES(out_modeAES)
`ifdef NLU_ISSUE_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    typedef struct {
        logic [31:0] a;
        logic        modenl;
        logic        modeAES;
        logic [63:0] m;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_mask, m_shadow;
    logic        m_pending, m_ready;
    int unsigned m_issued, m_stall;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        else pass_cnt++;
    endtask

    task automatic model_reset();
        q.delete();
        m_mask = MASK_RST; m_shadow = 64'h0;
        m_pending = 1'b0; m_ready = 1'b0;
        m_issued = 0; m_stall = 0;
    endtask

    // One clock edge of the specified behaviour, evaluated from the bench's own inputs.
    task automatic model_step();
        bit push, pop, hi, empty_now;
        ent_t e;
        push = in_valid && m_ready;
        pop  = (q.size() > 0) && out_ready;
        hi   = cfg_we && cfg_addr;
        if (in_valid && !m_ready) m_stall++;
        if (pop) m_issued++;
        if (cfg_we && !cfg_addr) m_shadow[31:0] = cfg_wdata;
        if (hi) m_shadow[63:32] = cfg_wdata;
        empty_now = (q.size() == 0);
        if (hi) m_pending = 1'b1;
        if (m_pending && empty_now && !push) begin
            m_mask = m_shadow;
            m_pending = 1'b0;
        end
        e.a = in_a; e.modenl = in_modenl; e.modeAES = in_modeAES; e.m = m_mask;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(e);
        m_ready = (q.size() < DEPTH) && !m_pending;
    endtask

    task automatic compare();
        chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
        chk("cfg_busy", {63'd0, cfg_busy}, {63'd0, m_pending});
        chk("out_m", out_m, m_mask);
        if (q.size() > 0) begin
            chk("out_a", {32'd0, out_a}, {32'd0, q[0].a});
            chk("out_modenl", {63'd0, out_modenl}, {63'd0, q[0].modenl});
            chk("out_modeAES", {63'd0, out_modeAES}, {63'd0, q[0].modeAES});
            if (!q[0].modenl) chk("mask_at_accept", out_m, q[0].m);
        end
`ifdef NLU_ISSUE_PERF_EN
        chk("perf_issued", {32'd0, perf_issued}, {32'd0, m_issued});
        chk("perf_stall", {32'd0, perf_stall}, {32'd0, m_stall});
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_inputs();
        cfg_we = 1'b0; cfg_addr = 1'b0; cfg_wdata = 32'd0;
        in_valid = 1'b0; in_a = 32'd0; in_modenl = 1'b0; in_modeAES = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        compare();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_one(input logic [31:0] a, input logic nl);
        in_valid = 1'b1; in_a = a; in_modenl = nl; in_modeAES = a[0];
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_m", out_m, 64'h0);
        do_reset();
        chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

        // single push
        out_ready = 1'b1;
        push_one(32'h0123_4567, 1'b1);
        chk("single_valid", {63'd0, out_valid}, 64'd1);
        chk("single_a", {32'd0, out_a}, 64'h0123_4567);
        tick();
        chk("single_drained", {63'd0, out_valid}, 64'd0);

        // mask load while empty
        cfg_we = 1'b1; cfg_addr = 1'b0; cfg_wdata = 32'hDEAD_BEEF;
        tick();
        cfg_addr = 1'b1; cfg_wdata = 32'h0F0F_0F0F;
        tick();
        cfg_we = 1'b0;
        chk("empty_commit_m", out_m, 64'h0F0F0F0F_DEADBEEF);
        chk("empty_commit_busy", {63'd0, cfg_busy}, 64'd0);

        // backpressure: fill, hold a fifth, then drain in order
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_one(32'h1000 + i, 1'b0);
        chk("full_ready", {63'd0, in_ready}, 64'd0);
        in_valid = 1'b1; in_a = 32'h1004;
        repeat (3) tick();
        chk("held_head", {32'd0, out_a}, 64'h1000);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();

        // mask update with two queued entries
        out_ready = 1'b0;
        push_one(32'h2000, 1'b0);
        push_one(32'h2001, 1'b0);
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 32'hA5A5_A5A5;
        tick();
        cfg_we = 1'b0;
        chk("pend_busy", {63'd0, cfg_busy}, 64'd1);
        chk("pend_ready", {63'd0, in_ready}, 64'd0);
        chk("pend_old_m", out_m, 64'h0F0F0F0F_DEADBEEF);
        in_valid = 1'b1; in_a = 32'h2002;
        repeat (2) tick();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("pend_done_busy", {63'd0, cfg_busy}, 64'd0);
        chk("pend_new_m", out_m, 64'hA5A5A5A5_DEADBEEF);

        // steady push+pop at count 2
        out_ready = 1'b0;
        push_one(32'h3000, 1'b1);
        push_one(32'h3001, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_a = 32'h3002 + i; in_modenl = 1'b1;
            tick();
        end
        chk("steady_head", {32'd0, out_a}, 64'h300A);
        in_valid = 1'b0;
        repeat (3) tick();

        // reset while a commit is pending
        out_ready = 1'b0;
        push_one(32'h4000, 1'b0);
        push_one(32'h4001, 1'b0);
        cfg_we = 1'b1; cfg_addr = 1'b1; cfg_wdata = 32'h1234_5678;
        tick();
        cfg_we = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_m", out_m, MASK_RST);
        chk("midrst_busy", {63'd0, cfg_busy}, 64'd0);
        do_reset();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_a       = $urandom;
            in_modenl  = $urandom_range(0, 1);
            in_modeAES = $urandom_range(0, 1);
            out_ready  = ($urandom_range(0, 2) != 0);
            cfg_we     = ($urandom_range(0, 9) == 0);
            cfg_addr   = $urandom_range(0, 1);
            cfg_wdata  = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
